// File: rtl/tpic_refresh_ctrl.sv
// Serializes the relay image into a daisy-chained TPIC driver string, latches it,
// and checks the previously latched frame as it comes back out of the chain's SO pin.
module tpic_refresh_ctrl #(
  parameter int unsigned WIDTH       = 432,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned REFRESH_CYC = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             force_req,
  input  logic             err_clr,
  input  logic             sin,
  output logic             sclk,
  output logic             sout,
  output logic             rck,
  output logic             g_n,
  output logic             busy,
  output logic             frame_done,
  output logic             verify_err,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW     = $clog2(WIDTH);
  localparam int unsigned TW     = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam int unsigned RLAST  = (REFRESH_CYC == 0) ? 0 : REFRESH_CYC - 1;
  localparam logic [TW-1:0] RLAST_T = TW'(RLAST);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    div_cnt;
  logic             hi;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg, snap, cap, last_sent;
  logic             hold_bit;
  logic             have_prev;
  logic             pending;
  logic [TW-1:0]    timer;

  logic div_last, bit_last, timer_exp, start;

  assign div_last  = (div_cnt == DW'(CLK_DIV - 1));
  assign bit_last  = (bit_cnt == BW'(WIDTH - 1));
  assign timer_exp = (REFRESH_CYC != 0) && (timer == RLAST_T);
  assign start     = pending | force_req | (data != last_sent) | timer_exp;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sclk       = 1'b0;
    sout       = 1'b0;
    rck        = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD: begin
        busy      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        sclk = hi;
        // shreg has already advanced in the high phase, so hold the bit being clocked
        sout = hi ? hold_bit : shreg[WIDTH-1];
        if (div_last && hi && bit_last) state_nxt = LATCH;
      end
      LATCH: begin
        busy = 1'b1;
        rck  = 1'b1;
        if (div_last) begin
          frame_done = 1'b1;
          state_nxt  = GAP;
        end
      end
      GAP: begin
        busy = 1'b1;
        if (div_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt    <= '0;
      hi         <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      snap       <= '0;
      cap        <= '0;
      last_sent  <= '0;
      hold_bit   <= 1'b0;
      have_prev  <= 1'b0;
      pending    <= 1'b0;
      timer      <= '0;
      g_n        <= 1'b1;
      verify_err <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (state == IDLE && !start) timer <= timer + TW'(1);
      else                         timer <= '0;

      if (state == LOAD)                     pending <= force_req;
      else if (state != IDLE && force_req)   pending <= 1'b1;

      if (state == SHIFT || state == LATCH || state == GAP)
        div_cnt <= div_last ? '0 : div_cnt + DW'(1);
      else
        div_cnt <= '0;

      if (state == LOAD) begin
        shreg   <= data;
        snap    <= data;
        bit_cnt <= '0;
        hi      <= 1'b0;
      end

      if (state == SHIFT && div_last) begin
        if (!hi) begin
          cap      <= {cap[WIDTH-2:0], sin};
          hold_bit <= shreg[WIDTH-1];
          shreg    <= {shreg[WIDTH-2:0], 1'b0};
          hi       <= 1'b1;
        end else begin
          hi      <= 1'b0;
          bit_cnt <= bit_cnt + BW'(1);
        end
      end

      // compare against last_sent before it is overwritten with this frame's image
      if (state == LATCH && div_last) begin
        frame_cnt <= frame_cnt + 16'd1;
        last_sent <= snap;
        g_n       <= 1'b0;
        have_prev <= 1'b1;
      end

      if (state == LATCH && div_last && have_prev && (cap != last_sent))
        verify_err <= 1'b1;
      else if (err_clr)
        verify_err <= 1'b0;
    end
  end

endmodule
